history_buffer: RTL and testbench

- Parametrised successor to the game's guess-history block: records each confirmed guess and its feedback score into a DEPTH-entry register file.
- In history mode, the stored turns can be browsed with up/down buttons.
- Sits between the guess-entry logic and the display mux; the display shows selection/feedback, and last_turn feeds the end-game logic.
- New over the previous generation: parametrised peg count/colour width/depth, stored feedback, internal button edge detection, optional wrap-around browsing, explicit empty/valid flags.

---
 rtl/history_pkg.sv | 41 ++++
 rtl/btn_edge.sv | 25 ++
 rtl/history_buffer.sv | 129 ++++++++++++
 tb/tb_history_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/history_pkg.sv
// Shared constants and helpers for the guess-history buffer: default geometry,
// a constant-evaluable clog2, and the packed layout of one stored turn.
package history_pkg;

  localparam int DEF_PEGS    = 4;
  localparam int DEF_COLOR_W = 3;
  localparam int DEF_DEPTH   = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_GUESS_W = DEF_PEGS * DEF_COLOR_W;
  localparam int DEF_FB_W    = clog2(DEF_PEGS + 1);
  localparam int DEF_ENTRY_W = DEF_GUESS_W + 2 * DEF_FB_W;

  // One turn as stored: guess in the MSBs, then black, then white.
  typedef struct packed {
    logic [DEF_GUESS_W-1:0] guess;
    logic [DEF_FB_W-1:0]    black;
    logic [DEF_FB_W-1:0]    white;
  } entry_t;

  function automatic entry_t pack_entry(input logic [DEF_GUESS_W-1:0] guess,
                                        input logic [DEF_FB_W-1:0]    black,
                                        input logic [DEF_FB_W-1:0]    white);
    entry_t e;
    e.guess = guess;
    e.black = black;
    e.white = white;
    return e;
  endfunction

  function automatic entry_t unpack_entry(input logic [DEF_ENTRY_W-1:0] bits);
    return entry_t'(bits);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse from a debounced level button. The first cycle after reset
// release is masked so a button held through reset never fires.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_btn;
      r_armed <= 1'b1;
    end
  end

  assign o_pulse = r_armed & i_btn & ~r_prev;

endmodule

// File: rtl/history_buffer.sv
// Records confirmed guesses with their feedback and lets the player browse the
// stored turns in history mode; guess mode mirrors the live guess.
module history_buffer
  import history_pkg::*;
#(
  parameter int  PEGS    = DEF_PEGS,
  parameter int  COLOR_W = DEF_COLOR_W,
  parameter int  DEPTH   = DEF_DEPTH,
  parameter bit  WRAP    = 1'b0,
  localparam int IDX_W   = clog2(DEPTH),
  localparam int CNT_W   = clog2(DEPTH + 1),
  localparam int FB_W    = clog2(PEGS + 1),
  localparam int GUESS_W = PEGS * COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_select,
  input  logic [GUESS_W-1:0] guess,
  input  logic [FB_W-1:0]    fb_black,
  input  logic [FB_W-1:0]    fb_white,
  output logic [GUESS_W-1:0] selection,
  output logic [FB_W-1:0]    sel_black,
  output logic [FB_W-1:0]    sel_white,
  output logic [IDX_W-1:0]   selected_turn,
  output logic [CNT_W-1:0]   turn_count,
  output logic               view_valid,
  output logic               last_turn
);

  localparam int               ENTRY_W = GUESS_W + 2 * FB_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);

  logic w_up;
  logic w_down;
  logic w_sel;

  btn_edge u_edge_up   (.clk(clk), .rst_n(reset), .i_btn(btn_up),     .o_pulse(w_up));
  btn_edge u_edge_down (.clk(clk), .rst_n(reset), .i_btn(btn_down),   .o_pulse(w_down));
  btn_edge u_edge_sel  (.clk(clk), .rst_n(reset), .i_btn(btn_select), .o_pulse(w_sel));

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mode_prev;
  logic [GUESS_W-1:0] r_sel;
  logic [FB_W-1:0]    r_blk;
  logic [FB_W-1:0]    r_wht;
  logic [IDX_W-1:0]   r_turn;
  logic               r_valid;

  logic               w_record;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [IDX_W-1:0]   w_newest;
  logic [IDX_W-1:0]   w_idx_next;
  logic [ENTRY_W-1:0] w_rd;

  // Recording uses the live mode level, so a select arriving with mode=1 is dropped.
  assign w_record   = w_sel & ~mode & (r_cnt < DEPTH_C);
  assign w_cnt_next = w_record ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_newest   = (r_cnt == '0) ? '0 : IDX_W'(r_cnt - CNT_W'(1));

  always_comb begin
    w_idx_next = r_idx;
    if (!mode) begin
      w_idx_next = '0;
    end else if (!r_mode_prev) begin
      w_idx_next = w_newest;
    end else if (w_up && !w_down) begin
      if (r_idx != '0)  w_idx_next = r_idx - IDX_W'(1);
      else if (WRAP)    w_idx_next = w_newest;
    end else if (w_down && !w_up) begin
      if (r_idx != w_newest) w_idx_next = r_idx + IDX_W'(1);
      else if (WRAP)         w_idx_next = '0;
    end
  end

  assign w_rd = r_mem[w_idx_next];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_mode_prev <= 1'b0;
      r_sel       <= '0;
      r_blk       <= '0;
      r_wht       <= '0;
      r_turn      <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (w_record) r_mem[r_cnt[IDX_W-1:0]] <= {guess, fb_black, fb_white};
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_mode_prev <= mode;
      if (!mode) begin
        r_sel   <= guess;
        r_blk   <= fb_black;
        r_wht   <= fb_white;
        r_turn  <= (w_cnt_next >= DEPTH_C) ? IDX_MAX : w_cnt_next[IDX_W-1:0];
        r_valid <= 1'b0;
      end else if (r_cnt == '0) begin
        r_sel   <= '0;
        r_blk   <= '0;
        r_wht   <= '0;
        r_turn  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_sel   <= w_rd[ENTRY_W-1 -: GUESS_W];
        r_blk   <= w_rd[2*FB_W-1 -: FB_W];
        r_wht   <= w_rd[FB_W-1:0];
        r_turn  <= w_idx_next;
        r_valid <= 1'b1;
      end
    end
  end

  assign selection     = r_sel;
  assign sel_black     = r_blk;
  assign sel_white     = r_wht;
  assign selected_turn = r_turn;
  assign turn_count    = r_cnt;
  assign view_valid    = r_valid;
  assign last_turn     = (r_cnt == DEPTH_C);

endmodule

// File: tb/tb_history_buffer.sv
// Bench for history_buffer: a saturating (WRAP=0) and a wrapping (WRAP=1)
// instance share stimulus; expected views are queued and compared per sample.
module tb_history_buffer;

  localparam int GW = 12;
  localparam int FW = 3;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int OW = GW + 2*FW + IW + CW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode, btn_up, btn_down, btn_select;
  logic [GW-1:0] guess;
  logic [FW-1:0] fb_black, fb_white;

  logic [GW-1:0] sel0, sel1;
  logic [FW-1:0] blk0, blk1, wht0, wht1;
  logic [IW-1:0] trn0, trn1;
  logic [CW-1:0] cnt0, cnt1;
  logic          vld0, vld1, lst0, lst1;

  logic [2*OW-1:0] exp_q[$];
  logic [2*OW-1:0] e;
  int checks = 0;
  int errors = 0;

  logic [GW-1:0] rec_g [8];
  logic [FW-1:0] rec_b [8];
  logic [FW-1:0] rec_w [8];

  always #5 clk = ~clk;

  history_buffer #(.WRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_select(btn_select), .guess(guess), .fb_black(fb_black), .fb_white(fb_white),
    .selection(sel0), .sel_black(blk0), .sel_white(wht0), .selected_turn(trn0),
    .turn_count(cnt0), .view_valid(vld0), .last_turn(lst0)
  );

  history_buffer #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_select(btn_select), .guess(guess), .fb_black(fb_black), .fb_white(fb_white),
    .selection(sel1), .sel_black(blk1), .sel_white(wht1), .selected_turn(trn1),
    .turn_count(cnt1), .view_valid(vld1), .last_turn(lst1)
  );

  function automatic logic [OW-1:0] mk(input logic [GW-1:0] s, input logic [FW-1:0] b,
                                       input logic [FW-1:0] w, input logic [IW-1:0] t,
                                       input logic [CW-1:0] c, input logic v, input logic l);
    return {s, b, w, t, c, v, l};
  endfunction

  function automatic logic [2*OW-1:0] obs();
    return {sel0, blk0, wht0, trn0, cnt0, vld0, lst0, sel1, blk1, wht1, trn1, cnt1, vld1, lst1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input logic [GW-1:0] g, input logic [FW-1:0] b, input logic [FW-1:0] w);
    guess = g; fb_black = b; fb_white = w;
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    tick();
  endtask

  task automatic press_up();
    btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
  endtask

  task automatic press_down();
    btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b1;
    guess = 12'hABC; fb_black = 3'd2; fb_white = 3'd1;
    repeat (3) tick();
    exp_q.push_back({mk('0, '0, '0, '0, '0, 1'b0, 1'b0), mk('0, '0, '0, '0, '0, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs(), e); end
    reset = 1'b1;
    tick();
    exp_q.push_back({mk(12'hABC, 3'd2, 3'd1, 3'd0, 4'd0, 1'b0, 1'b0), mk(12'hABC, 3'd2, 3'd1, 3'd0, 4'd0, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs(), e); end
    tick();
    exp_q.push_back({mk(12'hABC, 3'd2, 3'd1, 3'd0, 4'd0, 1'b0, 1'b0), mk(12'hABC, 3'd2, 3'd1, 3'd0, 4'd0, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL held_select_through_reset got=%h exp=%h", obs(), e); end
    btn_select = 1'b0;
    tick();
  endtask

  task automatic test_record();
    rec_g[0] = 12'h001; rec_b[0] = 3'd1; rec_w[0] = 3'd0;
    guess = rec_g[0]; fb_black = rec_b[0]; fb_white = rec_w[0];
    btn_select = 1'b1;
    tick();
    exp_q.push_back({mk(12'h001, 3'd1, 3'd0, 3'd1, 4'd1, 1'b0, 1'b0), mk(12'h001, 3'd1, 3'd0, 3'd1, 4'd1, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL record_first got=%h exp=%h", obs(), e); end
    repeat (4) tick();
    exp_q.push_back({mk(12'h001, 3'd1, 3'd0, 3'd1, 4'd1, 1'b0, 1'b0), mk(12'h001, 3'd1, 3'd0, 3'd1, 4'd1, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL record_held_once got=%h exp=%h", obs(), e); end
    btn_select = 1'b0;
    tick();
  endtask

  task automatic test_history();
    rec_g[1] = 12'h008; rec_b[1] = 3'd0; rec_w[1] = 3'd2;
    record(rec_g[1], rec_b[1], rec_w[1]);
    exp_q.push_back({mk(12'h008, 3'd0, 3'd2, 3'd2, 4'd2, 1'b0, 1'b0), mk(12'h008, 3'd0, 3'd2, 3'd2, 4'd2, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL record_second got=%h exp=%h", obs(), e); end
    mode = 1'b1;
    tick();
    exp_q.push_back({mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0), mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL enter_history got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_saturate_wrap();
    btn_down = 1'b1;
    tick();
    exp_q.push_back({mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0), mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL down_at_newest got=%h exp=%h", obs(), e); end
    repeat (3) tick();
    exp_q.push_back({mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0), mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL down_held got=%h exp=%h", obs(), e); end
    btn_down = 1'b0;
    tick();
    press_up();
    exp_q.push_back({mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0), mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL up_first got=%h exp=%h", obs(), e); end
    press_up();
    exp_q.push_back({mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0), mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL up_second got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    btn_up = 1'b1; btn_down = 1'b1;
    tick();
    btn_up = 1'b0; btn_down = 1'b0;
    tick();
    exp_q.push_back({mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0), mk(12'h001, 3'd1, 3'd0, 3'd0, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL up_down_same_cycle got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_leave();
    mode = 1'b0; guess = 12'h123; fb_black = 3'd1; fb_white = 3'd1;
    tick();
    exp_q.push_back({mk(12'h123, 3'd1, 3'd1, 3'd2, 4'd2, 1'b0, 1'b0), mk(12'h123, 3'd1, 3'd1, 3'd2, 4'd2, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL leave_history got=%h exp=%h", obs(), e); end
    mode = 1'b1; btn_select = 1'b1;
    tick();
    exp_q.push_back({mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0), mk(12'h008, 3'd0, 3'd2, 3'd1, 4'd2, 1'b1, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reenter_with_select got=%h exp=%h", obs(), e); end
    btn_select = 1'b0; mode = 1'b0;
    tick();
    exp_q.push_back({mk(12'h123, 3'd1, 3'd1, 3'd2, 4'd2, 1'b0, 1'b0), mk(12'h123, 3'd1, 3'd1, 3'd2, 4'd2, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL no_record_in_history got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_full();
    logic [GW-1:0] g9;
    logic [IW-1:0] t;
    for (int i = 2; i < 8; i++) begin
      rec_g[i] = GW'($urandom_range(0, 4095));
      rec_b[i] = FW'($urandom_range(0, 4));
      rec_w[i] = FW'($urandom_range(0, 4 - int'(rec_b[i])));
      record(rec_g[i], rec_b[i], rec_w[i]);
      t = (i + 1 > 7) ? 3'd7 : IW'(i + 1);
      exp_q.push_back({mk(rec_g[i], rec_b[i], rec_w[i], t, CW'(i + 1), 1'b0, i == 7),
                       mk(rec_g[i], rec_b[i], rec_w[i], t, CW'(i + 1), 1'b0, i == 7)});
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL fill_turn_%0d got=%h exp=%h", i, obs(), e); end
    end
    g9 = rec_g[7] ^ 12'hFFF;
    record(g9, 3'd3, 3'd1);
    exp_q.push_back({mk(g9, 3'd3, 3'd1, 3'd7, 4'd8, 1'b0, 1'b1), mk(g9, 3'd3, 3'd1, 3'd7, 4'd8, 1'b0, 1'b1)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL ninth_select got=%h exp=%h", obs(), e); end
    mode = 1'b1;
    tick();
    exp_q.push_back({mk(rec_g[7], rec_b[7], rec_w[7], 3'd7, 4'd8, 1'b1, 1'b1), mk(rec_g[7], rec_b[7], rec_w[7], 3'd7, 4'd8, 1'b1, 1'b1)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL entry7_intact got=%h exp=%h", obs(), e); end
    press_up();
    exp_q.push_back({mk(rec_g[6], rec_b[6], rec_w[6], 3'd6, 4'd8, 1'b1, 1'b1), mk(rec_g[6], rec_b[6], rec_w[6], 3'd6, 4'd8, 1'b1, 1'b1)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL full_browse_up got=%h exp=%h", obs(), e); end
    press_down();
    exp_q.push_back({mk(rec_g[7], rec_b[7], rec_w[7], 3'd7, 4'd8, 1'b1, 1'b1), mk(rec_g[7], rec_b[7], rec_w[7], 3'd7, 4'd8, 1'b1, 1'b1)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL full_browse_down got=%h exp=%h", obs(), e); end
    press_down();
    exp_q.push_back({mk(rec_g[7], rec_b[7], rec_w[7], 3'd7, 4'd8, 1'b1, 1'b1), mk(rec_g[0], rec_b[0], rec_w[0], 3'd0, 4'd8, 1'b1, 1'b1)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL full_down_at_end got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back({mk('0, '0, '0, '0, '0, 1'b0, 1'b0), mk('0, '0, '0, '0, '0, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL async_reset_immediate got=%h exp=%h", obs(), e); end
    mode = 1'b0; guess = 12'h5A5; fb_black = 3'd4; fb_white = 3'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    exp_q.push_back({mk(12'h5A5, 3'd4, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0), mk(12'h5A5, 3'd4, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0)});
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL after_async_reset got=%h exp=%h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_record();
    test_history();
    test_saturate_wrap();
    test_back_to_back();
    test_leave();
    test_full();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
